// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes,
// FSM state encoding, operand bundle and the divide-by-zero LO value.
package md_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef struct packed {
        logic            sgn;
        logic [XLEN-1:0] opa;
        logic [XLEN-1:0] opb;
    } md_opnd_t;

    // Multi-cycle ops that freeze the front of the pipe.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter timing the external multiplier latency.
module md_lat_cnt
    import md_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Flags the cycle whose decrement lands the count on zero.
    assign o_zero = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// HI/LO controller: sequences external multiplier/divider, stalls the
// front of the pipe and performs exactly one HI/LO write per accepted op.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              stallreq,
    output logic              busy,
    output logic              mul_signed,
    output logic [XLEN-1:0]   mul_opa,
    output logic [XLEN-1:0]   mul_opb,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              div_start,
    output logic              div_signed,
    output logic              div_annul,
    output logic [XLEN-1:0]   div_opa,
    output logic [XLEN-1:0]   div_opb,
    input  logic              div_ready,
    input  logic [2*XLEN-1:0] div_result,
    output logic              hi_we,
    output logic              lo_we,
    output logic [XLEN-1:0]   hi_wdata,
    output logic [XLEN-1:0]   lo_wdata
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    md_opnd_t          r_opnd;
    md_opnd_t          w_opnd_nxt;
    logic [2*XLEN-1:0] r_result;
    logic [2*XLEN-1:0] w_result_nxt;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_op_vld;
    logic              w_in_mul;
    logic              w_in_div;

    // Reset also masks the combinational IDLE decode so every output is quiet.
    assign w_op_vld = op_valid & resetn;
    assign w_in_mul = (r_state == ST_MUL_WAIT);
    assign w_in_div = (r_state == ST_DIV_RUN);

    md_lat_cnt u_lat_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(MUL_LAT)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_opnd   <= w_opnd_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_opnd_nxt   = r_opnd;
        w_result_nxt = r_result;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        stallreq     = 1'b0;
        div_start    = 1'b0;
        div_annul    = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wdata     = '0;
        lo_wdata     = '0;
        case (r_state)
            ST_IDLE: begin
                stallreq = w_op_vld & is_md_op(op_code);
                if (w_op_vld && !flush) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            w_opnd_nxt.sgn = (op_code == OP_MULT);
                            w_opnd_nxt.opa = src_a;
                            w_opnd_nxt.opb = src_b;
                            w_cnt_load     = 1'b1;
                            w_state_nxt    = ST_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == '0) begin
                                // Divide-by-zero never reaches the divider.
                                w_result_nxt = {src_a, DIV0_LO};
                                w_state_nxt  = ST_DONE;
                            end else begin
                                w_opnd_nxt.sgn = (op_code == OP_DIV);
                                w_opnd_nxt.opa = src_a;
                                w_opnd_nxt.opb = src_b;
                                w_state_nxt    = ST_DIV_RUN;
                            end
                        end
                        OP_MTHI: begin
                            hi_we    = ~pipe_stall;
                            hi_wdata = src_a;
                        end
                        OP_MTLO: begin
                            lo_we    = ~pipe_stall;
                            lo_wdata = src_a;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                stallreq = 1'b1;
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_zero) begin
                        w_result_nxt = mul_result;
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DIV_RUN: begin
                stallreq  = 1'b1;
                div_start = ~div_ready;
                if (flush) begin
                    // Flush beats a simultaneous div_ready; result is dropped.
                    div_annul   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (div_ready) begin
                    w_result_nxt = div_result;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pipe_stall) begin
                    hi_we       = 1'b1;
                    lo_we       = 1'b1;
                    hi_wdata    = r_result[2*XLEN-1:XLEN];
                    lo_wdata    = r_result[XLEN-1:0];
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign mul_signed = w_in_mul & r_opnd.sgn;
    assign mul_opa    = w_in_mul ? r_opnd.opa : '0;
    assign mul_opb    = w_in_mul ? r_opnd.opb : '0;
    assign div_signed = w_in_div & r_opnd.sgn;
    assign div_opa    = w_in_div ? r_opnd.opa : '0;
    assign div_opb    = w_in_div ? r_opnd.opb : '0;

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized scoreboard bench for md_ctrl with behavioural mul/div models.
module tb_md_ctrl;

    localparam int unsigned MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a, src_b;
    logic        flush, pipe_stall;
    logic        stallreq, busy;
    logic        mul_signed;
    logic [31:0] mul_opa, mul_opb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul;
    logic [31:0] div_opa, div_opb;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    typedef struct packed {
        logic        hw;
        logic        lw;
        logic [31:0] hd;
        logic [31:0] ld;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    logic [199:0] all_outs;
    logic [5:0]   ctl;
    logic [129:0] opnd;

    assign all_outs = {stallreq, busy, mul_signed, mul_opa, mul_opb, div_start, div_signed,
                       div_annul, div_opa, div_opb, hi_we, lo_we, hi_wdata, lo_wdata};
    assign ctl      = {busy, stallreq, div_start, div_annul, hi_we, lo_we};
    assign opnd     = {mul_signed, mul_opa, mul_opb, div_signed, div_opa, div_opb};

    always #5 clk = ~clk;

    md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .stallreq   (stallreq),
        .busy       (busy),
        .mul_signed (mul_signed),
        .mul_opa    (mul_opa),
        .mul_opb    (mul_opb),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_annul  (div_annul),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .div_ready  (div_ready),
        .div_result (div_result),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // {HI,LO} architectural result of an op, from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            3'd1: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                return 64'(ua * ub);
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Scoreboard monitor: every HI/LO write must match the oldest expectation.
    always @(negedge clk) begin
        wr_t act, e;
        if (hi_we || lo_we) begin
            act = {hi_we, lo_we, hi_we ? hi_wdata : 32'd0, lo_we ? lo_wdata : 32'd0};
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 256'(act), 256'd0);
            end else begin
                e = exp_q.pop_front();
                chk("hilo_write", 256'(act), 256'(e));
            end
        end
    end

    // One op from issue to return-to-IDLE. flush_at: cycle index of flush
    // (0 = issue cycle, -1 = none). nstall: DONE stall cycles, or for moves
    // a stalled issue. dlat: cycles of div_start before div_ready.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dlat, input int nstall, input int flush_at);
        bit          is_mul, is_div, is_mv, dz, wr_mv, aborted, run, fl, rdy, wr;
        logic [63:0] res;
        logic [129:0] opn_e;
        int          n_run, n_all, d;
        is_mul  = (op == 3'd0) || (op == 3'd1);
        is_div  = (op == 3'd2) || (op == 3'd3);
        is_mv   = (op == 3'd4) || (op == 3'd5);
        dz      = is_div && (b == 32'd0);
        res     = ref_result(op, a, b);
        n_run   = is_mul ? int'(MUL_LAT) : ((is_div && !dz) ? dlat + 1 : 0);
        n_all   = (is_mul || is_div) ? n_run + nstall + 1 : 0;
        aborted = (flush_at == 0) || (flush_at > 0 && flush_at <= n_all);
        wr_mv   = is_mv && (nstall == 0) && (flush_at != 0);

        op_valid   = 1'b1;
        op_code    = op;
        src_a      = a;
        src_b      = b;
        flush      = (flush_at == 0);
        pipe_stall = is_mv ? (nstall != 0) : 1'($urandom_range(0, 1));
        div_ready  = 1'b0;
        div_result = ~res;
        mul_result = ~res;
        if (wr_mv) exp_q.push_back(wr_t'({op == 3'd4, op == 3'd5,
                                          (op == 3'd4) ? a : 32'd0, (op == 3'd5) ? a : 32'd0}));
        if ((is_mul || is_div) && !aborted) exp_q.push_back(wr_t'({2'b11, res}));

        @(negedge clk);
        chk("issue_ctl", 256'(ctl), 256'({1'b0, is_mul || is_div, 2'b00,
                                           wr_mv && (op == 3'd4), wr_mv && (op == 3'd5)}));
        @(posedge clk); #1;

        if ((is_mul || is_div) && flush_at != 0) begin
            for (int c = 1; c <= n_all; c++) begin
                run = (c <= n_run);
                d   = c - n_run - 1;
                fl  = (c == flush_at);
                rdy = is_div && !dz && (c == n_run);
                wr  = !run && (d == nstall) && !fl;
                // EX keeps presenting junk while held; it must be ignored.
                op_valid   = 1'($urandom_range(0, 1));
                op_code    = 3'($urandom_range(0, 7));
                src_a      = $urandom;
                src_b      = $urandom;
                flush      = fl;
                pipe_stall = run ? 1'($urandom_range(0, 1)) : (d < nstall);
                div_ready  = rdy;
                div_result = rdy ? res : ~res;
                mul_result = (is_mul && c == int'(MUL_LAT)) ? res : ~res;
                opn_e = '0;
                if (run && is_mul) opn_e[129:65] = {op == 3'd0, a, b};
                if (run && is_div) opn_e[64:0]   = {op == 3'd2, a, b};
                @(negedge clk);
                chk("busy_ctl", 256'(ctl), 256'({1'b1, run, is_div && run && !rdy,
                                                 is_div && run && fl, wr, wr}));
                chk("operands", 256'(opnd), 256'(opn_e));
                @(posedge clk); #1;
                if (fl) break;
            end
        end

        op_valid   = 1'b0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        div_ready  = 1'b0;
        @(negedge clk);
        chk("idle_after", 256'({ctl, opnd}), 256'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          fa;

        resetn     = 1'b0;
        op_valid   = 1'b0;
        op_code    = 3'd0;
        src_a      = '0;
        src_b      = '0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        mul_result = '0;
        div_ready  = 1'b0;
        div_result = '0;
        #1 chk("reset_outs", 256'(all_outs), 256'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Directed cases.
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, -1);          // MULT -2 x 3
        run_op(3'd3, 32'd7, 32'd2, 33, 0, -1);                 // DIVU 7/2
        run_op(3'd2, 32'd5, 32'd0, 0, 0, -1);                  // DIV 5/0
        run_op(3'd2, 32'd1000, 32'd7, 40, 0, 10);              // flush mid-divide
        run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 3, -1);  // MULTU held in DONE
        run_op(3'd2, 32'hFFFF_FF00, 32'd9, 5, 0, 6);           // flush with div_ready
        run_op(3'd0, 32'd11, 32'd13, 0, 2, int'(MUL_LAT) + 2); // flush while in DONE
        run_op(3'd0, 32'd4, 32'd4, 0, 0, 1);                   // flush in MUL_WAIT
        run_op(3'd4, 32'hCAFE_0001, 32'd0, 0, 0, -1);          // MTHI
        run_op(3'd5, 32'hCAFE_0002, 32'd0, 0, 1, -1);          // MTLO stalled
        run_op(3'd4, 32'hCAFE_0003, 32'd0, 0, 0, 0);           // MTHI flushed
        run_op(3'd6, 32'h1, 32'h2, 0, 0, -1);                  // reserved
        run_op(3'd3, 32'h8000_0000, 32'd0, 0, 1, -1);          // DIVU by zero, stalled

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_op(op, a, b, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), fa);
        end

        // Reset in the middle of a divide, then an MTLO right after release.
        op_valid  = 1'b1;
        op_code   = 3'd3;
        src_a     = 32'd100;
        src_b     = 32'd7;
        div_ready = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("pre_reset_div", 256'({busy, stallreq, div_start}), 256'(3'b111));
            @(posedge clk); #1;
        end
        #2 resetn = 1'b0;
        #1 chk("async_reset_outs", 256'(all_outs), 256'd0);
        @(posedge clk); #1;
        chk("held_reset_outs", 256'(all_outs), 256'd0);
        resetn = 1'b1;
        run_op(3'd5, 32'h0000_1234, 32'd0, 0, 0, -1);

        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
